// File: rtl/pipeline_fetch_ctrl.sv
// pipeline_fetch_ctrl: IF-stage sequencing controller.
// Handles boot timing after reset, load-use stalls, branch/jump redirects
// with IF/ID and ID/EX flushes, and halt/resume.
// Optional performance counters are built only when FETCH_CTRL_PERF_EN is
// defined; otherwise stall_cnt_o/redirect_cnt_o are tied to zero.
module pipeline_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned BOOT_CYCLES  = 4,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              branch_taken_i,
  input  logic [31:0]       branch_target_i,
  input  logic              stall_i,
  input  logic              halt_i,
  input  logic              resume_i,
  input  logic              imem_ready_i,
  output logic              fetch_en_o,
  output logic              pc_src_o,
  output logic [31:0]       pc_new_o,
  output logic              flush_if_id_o,
  output logic              flush_id_ex_o,
  output logic              halted_o,
  output logic              misaligned_o,
  output logic [2:0]        state_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  redirect_cnt_o
);

  typedef enum logic [2:0] {
    ST_BOOT     = 3'd0,
    ST_RUN      = 3'd1,
    ST_STALL    = 3'd2,
    ST_REDIRECT = 3'd3,
    ST_HALT     = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] boot_cnt_q, boot_cnt_d;
  logic [2:0] flush_cnt_q, flush_cnt_d;
  logic       halt_pend_q, halt_pend_d;
  logic       halted_q, halted_d;
  logic       misaligned_q, misaligned_d;
  logic       redirect_acc;

  // Next-state, counter updates and combinational fetch-side controls.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    boot_cnt_d    = boot_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    halt_pend_d   = halt_pend_q;
    misaligned_d  = 1'b0;
    redirect_acc  = 1'b0;
    fetch_en_o    = 1'b0;
    pc_src_o      = 1'b0;
    pc_new_o      = RESET_VECTOR;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;

    case (state_q)
      ST_BOOT: begin
        flush_if_id_o = 1'b1;
        flush_id_ex_o = 1'b1;
        if (boot_cnt_q == 8'd0) begin
          // Last boot cycle: load the reset vector into the PC.
          pc_src_o   = 1'b1;
          fetch_en_o = 1'b1;
          state_d    = ST_RUN;
        end else begin
          boot_cnt_d = boot_cnt_q - 8'd1;
        end
      end

      ST_RUN, ST_STALL, ST_REDIRECT: begin
        if (branch_taken_i) begin
          // Redirect wins over everything, including a not-ready imem.
          redirect_acc  = 1'b1;
          pc_src_o      = 1'b1;
          pc_new_o      = {branch_target_i[31:2], 2'b00};
          fetch_en_o    = 1'b1;
          flush_if_id_o = 1'b1;
          flush_id_ex_o = 1'b1;
          misaligned_d  = |branch_target_i[1:0];
          flush_cnt_d   = 3'(FLUSH_CYCLES);
          state_d       = (FLUSH_CYCLES != 0) ? ST_REDIRECT : ST_RUN;
        end else if (state_q == ST_REDIRECT) begin
          flush_if_id_o = 1'b1;
          if (halt_i) begin
            state_d     = ST_HALT;
            halt_pend_d = 1'b0;
          end else begin
            // stall_i is ignored here; a not-ready imem holds the count.
            fetch_en_o = imem_ready_i;
            if (imem_ready_i) begin
              if (flush_cnt_q <= 3'd1) begin
                flush_cnt_d = 3'd0;
                state_d     = ST_RUN;
              end else begin
                flush_cnt_d = flush_cnt_q - 3'd1;
              end
            end
          end
        end else if (state_q == ST_STALL) begin
          // A halt arriving mid-stall is parked until the stall clears.
          halt_pend_d = halt_pend_q | halt_i;
          if (stall_i) begin
            flush_id_ex_o = 1'b1;
          end else begin
            fetch_en_o = imem_ready_i;
            state_d    = ST_RUN;
          end
        end else begin
          if (halt_i || halt_pend_q) begin
            flush_if_id_o = 1'b1;
            halt_pend_d   = 1'b0;
            state_d       = ST_HALT;
          end else if (stall_i) begin
            flush_id_ex_o = 1'b1;
            state_d       = ST_STALL;
          end else begin
            fetch_en_o = imem_ready_i;
          end
        end
      end

      ST_HALT: begin
        // resume_i wins over a simultaneous halt_i.
        if (resume_i) state_d = ST_RUN;
      end

      default: state_d = ST_BOOT;
    endcase

    if (reset_i) begin
      state_d      = ST_BOOT;
      boot_cnt_d   = 8'(BOOT_CYCLES - 1);
      flush_cnt_d  = 3'd0;
      halt_pend_d  = 1'b0;
      misaligned_d = 1'b0;
    end
  end

  assign halted_d = (state_d == ST_HALT);

  // Control-state registers.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge, independent of statement order.
    state_q      <= state_d;
    boot_cnt_q   <= boot_cnt_d;
    flush_cnt_q  <= flush_cnt_d;
    halt_pend_q  <= halt_pend_d;
    halted_q     <= halted_d;
    misaligned_q <= misaligned_d;
  end

  assign state_o      = state_q;
  assign halted_o     = halted_q;
  assign misaligned_o = misaligned_q;

`ifdef FETCH_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;
  logic             stall_inc;

  // Saturating stall and redirect counters.
  always_comb begin
    stall_inc      = (state_q == ST_STALL) || ((state_q == ST_RUN) && !imem_ready_i);
    stall_cnt_d    = stall_cnt_q;
    redirect_cnt_d = redirect_cnt_q;
    if (stall_inc && !(&stall_cnt_q))       stall_cnt_d    = stall_cnt_q + 1'b1;
    if (redirect_acc && !(&redirect_cnt_q)) redirect_cnt_d = redirect_cnt_q + 1'b1;
    if (reset_i) begin
      stall_cnt_d    = '0;
      redirect_cnt_d = '0;
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i) begin
    stall_cnt_q    <= stall_cnt_d;
    redirect_cnt_q <= redirect_cnt_d;
  end

  assign stall_cnt_o    = stall_cnt_q;
  assign redirect_cnt_o = redirect_cnt_q;
`else
  logic unused_perf;
  assign unused_perf    = redirect_acc;
  assign stall_cnt_o    = '0;
  assign redirect_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_fetch_ctrl.sv
// Directed testbench for pipeline_fetch_ctrl (BOOT_CYCLES=4, FLUSH_CYCLES=1,
// CNT_W=4). Inputs change 2 time units after a rising edge; outputs are
// checked 1 unit later, well away from the next edge.
module tb_pipeline_fetch_ctrl;

  localparam int CNT_W = 4;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic             branch_taken_i;
  logic [31:0]      branch_target_i;
  logic             stall_i;
  logic             halt_i;
  logic             resume_i;
  logic             imem_ready_i;
  logic             fetch_en_o;
  logic             pc_src_o;
  logic [31:0]      pc_new_o;
  logic             flush_if_id_o;
  logic             flush_id_ex_o;
  logic             halted_o;
  logic             misaligned_o;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] redirect_cnt_o;

  int total = 0;
  int bad   = 0;

  pipeline_fetch_ctrl #(
    .RESET_VECTOR (32'h0000_0000),
    .BOOT_CYCLES  (4),
    .FLUSH_CYCLES (1),
    .CNT_W        (CNT_W)
  ) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .stall_i         (stall_i),
    .halt_i          (halt_i),
    .resume_i        (resume_i),
    .imem_ready_i    (imem_ready_i),
    .fetch_en_o      (fetch_en_o),
    .pc_src_o        (pc_src_o),
    .pc_new_o        (pc_new_o),
    .flush_if_id_o   (flush_if_id_o),
    .flush_id_ex_o   (flush_id_ex_o),
    .halted_o        (halted_o),
    .misaligned_o    (misaligned_o),
    .state_o         (state_o),
    .stall_cnt_o     (stall_cnt_o),
    .redirect_cnt_o  (redirect_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and move to the drive point of the new cycle.
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset_i         = 1'b1;
    branch_taken_i  = 1'b0;
    branch_target_i = 32'h0;
    stall_i         = 1'b0;
    halt_i          = 1'b0;
    resume_i        = 1'b0;
    imem_ready_i    = 1'b1;

    // Boot: two reset cycles, then four BOOT cycles.
    tick();
    tick();
    reset_i = 1'b0;
    settle();
    check("rst_halted", halted_o, 0);
    check("rst_misal", misaligned_o, 0);
    check("rst_stall_cnt", stall_cnt_o, 0);
    check("rst_redir_cnt", redirect_cnt_o, 0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      settle();
      check($sformatf("boot%0d_state", i), state_o, 0);
      check($sformatf("boot%0d_flush_ifid", i), flush_if_id_o, 1);
      check($sformatf("boot%0d_flush_idex", i), flush_id_ex_o, 1);
      check($sformatf("boot%0d_pc_src", i), pc_src_o, (i == 3) ? 1 : 0);
      check($sformatf("boot%0d_fetch_en", i), fetch_en_o, (i == 3) ? 1 : 0);
      if (i == 3) check("boot_pc_new", pc_new_o, 32'h0);
    end
    tick();
    settle();
    check("run_state", state_o, 1);
    check("run_fetch_en", fetch_en_o, 1);
    check("run_pc_src", pc_src_o, 0);
    check("run_flush_ifid", flush_if_id_o, 0);

    // imem not ready in RUN: no fetch, state held.
    imem_ready_i = 1'b0;
    settle();
    check("nordy_fetch_en", fetch_en_o, 0);
    tick();
    settle();
    check("nordy_state", state_o, 1);
    imem_ready_i = 1'b1;

    // Branch with misaligned target 0x46.
    branch_taken_i  = 1'b1;
    branch_target_i = 32'h0000_0046;
    settle();
    check("br_pc_new", pc_new_o, 32'h44);
    check("br_pc_src", pc_src_o, 1);
    check("br_fetch_en", fetch_en_o, 1);
    check("br_flush_ifid", flush_if_id_o, 1);
    check("br_flush_idex", flush_id_ex_o, 1);
    tick();
    branch_taken_i = 1'b0;
    settle();
    check("redir_state", state_o, 3);
    check("redir_misal", misaligned_o, 1);
    check("redir_flush_ifid", flush_if_id_o, 1);
    check("redir_flush_idex", flush_id_ex_o, 0);
    check("redir_pc_src", pc_src_o, 0);
    tick();
    settle();
    check("redir_done_state", state_o, 1);
    check("redir_misal_clr", misaligned_o, 0);

    // Load-use stall for three cycles.
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      settle();
      check($sformatf("stall%0d_fetch_en", i), fetch_en_o, 0);
      check($sformatf("stall%0d_flush_idex", i), flush_id_ex_o, 1);
      check($sformatf("stall%0d_flush_ifid", i), flush_if_id_o, 0);
    end
    check("stall_state", state_o, 2);
    tick();
    stall_i = 1'b0;
    settle();
    check("stall_drop_fetch_en", fetch_en_o, 1);
    tick();
    settle();
    check("stall_exit_state", state_o, 1);

    // Branch during stall.
    stall_i = 1'b1;
    tick();
    branch_taken_i  = 1'b1;
    branch_target_i = 32'h0000_0100;
    settle();
    check("brstall_pc_src", pc_src_o, 1);
    check("brstall_fetch_en", fetch_en_o, 1);
    check("brstall_pc_new", pc_new_o, 32'h100);
    tick();
    branch_taken_i = 1'b0;
    settle();
    check("brstall_state", state_o, 3);
    check("brstall_misal", misaligned_o, 0);
    check("brstall_fetch_en2", fetch_en_o, 1);
    stall_i = 1'b0;
    tick();
    settle();
    check("brstall_run", state_o, 1);

    // Halt pulse in RUN; branch ignored while halted; resume.
    halt_i = 1'b1;
    settle();
    check("halt_fetch_en", fetch_en_o, 0);
    check("halt_flush_ifid", flush_if_id_o, 1);
    tick();
    halt_i = 1'b0;
    settle();
    check("halt_state", state_o, 4);
    check("halt_halted", halted_o, 1);
    branch_taken_i = 1'b1;
    settle();
    check("halt_br_pc_src", pc_src_o, 0);
    check("halt_br_fetch_en", fetch_en_o, 0);
    tick();
    branch_taken_i = 1'b0;
    settle();
    check("halt_br_state", state_o, 4);
    resume_i = 1'b1;
    tick();
    resume_i = 1'b0;
    settle();
    check("resume_state", state_o, 1);
    check("resume_halted", halted_o, 0);
    check("resume_fetch_en", fetch_en_o, 1);

    // Halt during stall is deferred until the stall clears.
    stall_i = 1'b1;
    tick();
    halt_i = 1'b1;
    settle();
    check("dhalt_fetch_en", fetch_en_o, 0);
    tick();
    halt_i = 1'b0;
    settle();
    check("dhalt_state_a", state_o, 2);
    check("dhalt_halted_a", halted_o, 0);
    tick();
    settle();
    check("dhalt_state_b", state_o, 2);
    stall_i = 1'b0;
    settle();
    check("dhalt_drop_fetch_en", fetch_en_o, 1);
    tick();
    settle();
    check("dhalt_run_state", state_o, 1);
    check("dhalt_run_fetch_en", fetch_en_o, 0);
    check("dhalt_run_flush_ifid", flush_if_id_o, 1);
    tick();
    settle();
    check("dhalt_halt_state", state_o, 4);
    check("dhalt_halted", halted_o, 1);

    // halt_i and resume_i together in HALT: resume wins.
    halt_i   = 1'b1;
    resume_i = 1'b1;
    tick();
    halt_i   = 1'b0;
    resume_i = 1'b0;
    settle();
    check("hr_state", state_o, 1);
    check("hr_halted", halted_o, 0);

    // Twenty back-to-back redirects.
    branch_taken_i  = 1'b1;
    branch_target_i = 32'h0000_0200;
    for (int i = 0; i < 20; i++) begin
      settle();
      check($sformatf("multi%0d_pc_src", i), pc_src_o, 1);
      tick();
    end
    branch_taken_i = 1'b0;
    settle();
    check("multi_state", state_o, 3);
`ifdef FETCH_CTRL_PERF_EN
    check("perf_redir_sat", redirect_cnt_o, 15);
`else
    check("perf_redir_off", redirect_cnt_o, 0);
    check("perf_stall_off", stall_cnt_o, 0);
`endif
    tick();

    // Reset from RUN returns to BOOT and clears counters.
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    settle();
    check("rerst_state", state_o, 0);
    check("rerst_fetch_en", fetch_en_o, 0);
    check("rerst_halted", halted_o, 0);
    check("rerst_redir_cnt", redirect_cnt_o, 0);
    check("rerst_stall_cnt", stall_cnt_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_fetch_ctrl.md
Name: pipeline_fetch_ctrl

Overview:
- Sequencing controller for the IF stage. It drives the fetch stage's PC-source select, redirect target and PC-advance enable.
- It owns boot timing after reset, load-use stalls, branch/jump redirects with IF/ID and ID/EX flushes, and halt/resume.
- It sits between the fetch stage, the hazard unit in decode and the branch resolver in EX.

Parameters:
- RESET_VECTOR, 32'h0000_0000, first PC loaded after boot.
- BOOT_CYCLES, 4, cycles held in BOOT after reset release; legal range 1..255.
- FLUSH_CYCLES, 1, extra IF/ID flush cycles after a redirect; legal range 0..7.
- CNT_W, 16, width of the performance counters.

Ports:
- clk_i  in  1  single clock, rising edge.
- reset_i  in  1  synchronous, active-high reset.
- branch_taken_i  in  1  EX resolved a taken branch or jump this cycle.
- branch_target_i  in  32  redirect target from EX.
- stall_i  in  1  load-use hazard from decode; level-sensitive.
- halt_i  in  1  ecall/ebreak retire request; single-cycle pulse.
- resume_i  in  1  leave HALT; single-cycle pulse.
- imem_ready_i  in  1  instruction memory can accept a fetch this cycle.
- fetch_en_o  out  1  PC may update this cycle.
- pc_src_o  out  1  1 = fetch loads pc_new_o; 0 = PC+4.
- pc_new_o  out  32  redirect PC, word aligned.
- flush_if_id_o  out  1  kill the IF/ID register contents.
- flush_id_ex_o  out  1  kill the ID/EX register contents.
- halted_o  out  1  core is in HALT.
- misaligned_o  out  1  registered pulse: last redirect target had bits[1:0] != 0.
- state_o  out  3  current state: BOOT=0, RUN=1, STALL=2, REDIRECT=3, HALT=4.
- stall_cnt_o  out  CNT_W  stall-cycle counter (optional feature).
- redirect_cnt_o  out  CNT_W  redirect counter (optional feature).

Behaviour:
- Clocking and reset: single clock. Reset is synchronous and active-high, sampled on the rising edge of clk_i.
- While reset_i is high (registered effect):
  - state = BOOT; boot counter = BOOT_CYCLES-1; FLUSH counter = 0.
  - fetch_en_o=0, pc_src_o=0, pc_new_o=RESET_VECTOR, flush_if_id_o=1, flush_id_ex_o=1.
  - halted_o=0, misaligned_o=0, counters=0.
- Output timing: state_o, halted_o, misaligned_o and the counters are registered. fetch_en_o, pc_src_o, pc_new_o and the flushes are combinational from state and inputs.
- BOOT:
  - fetch_en_o=0 and both flushes=1; the counter decrements each cycle.
  - When the counter reaches 0: pc_src_o=1, fetch_en_o=1, pc_new_o=RESET_VECTOR, then go to RUN.
  - Inputs are ignored in BOOT.
- Priority in RUN/STALL/REDIRECT: branch_taken_i > halt_i > stall_i > imem_ready_i.
- Redirect (branch_taken_i=1 in RUN, STALL or REDIRECT):
  - pc_src_o=1, pc_new_o={branch_target_i[31:2],2'b00}, fetch_en_o=1 regardless of stall_i and imem_ready_i.
  - Both flushes=1.
  - misaligned_o is set the next cycle if target[1:0]!=0.
  - Next state: REDIRECT with FLUSH counter=FLUSH_CYCLES if FLUSH_CYCLES>0; else RUN.
- REDIRECT:
  - flush_if_id_o=1, flush_id_ex_o=0, fetch_en_o=imem_ready_i, pc_src_o=0.
  - The counter decrements; at 0 go to RUN.
  - stall_i is ignored here.
  - A new branch_taken_i restarts the redirect: new target, counter reloaded.
- RUN:
  - fetch_en_o = imem_ready_i & ~stall_i; pc_src_o=0; flushes=0.
  - stall_i=1 -> STALL.
  - halt_i=1 -> HALT, with fetch_en_o=0 and flush_if_id_o=1 that cycle.
- STALL:
  - fetch_en_o=0; flush_id_ex_o=1 (bubble insert); flush_if_id_o=0.
  - stall_i=0 -> RUN; fetch resumes in the same cycle stall_i drops, gated by imem_ready_i.
  - halt_i in STALL is held off until the stall clears. The request is remembered in a pending bit; HALT is entered on the first RUN cycle.
- HALT:
  - fetch_en_o=0 and halted_o=1; branch_taken_i and stall_i are ignored.
  - resume_i=1 -> RUN next cycle, with PC+4 continuation.
  - halt_i and resume_i in the same cycle: resume wins.
- imem_ready_i=0: fetch_en_o=0, state unchanged. A redirect overrides this (the target is captured via pc_src_o/fetch_en_o).
- Reset asserted in any state: BOOT on the next edge; pending halt and counters are cleared.

Optional Feature:
- Macro FETCH_CTRL_PERF_EN.
- Defined:
  - stall_cnt_o increments each cycle in STALL or with RUN & ~imem_ready_i.
  - redirect_cnt_o increments on each accepted branch_taken_i.
  - Both saturate at all-ones and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are synthesized.

Test Plan:
1. Boot: reset_i high 2 cycles, then low. Required: state_o=0 for 4 cycles; pc_src_o=1, pc_new_o=0x0 on the 4th cycle; state_o=1 after.
2. Branch: RUN, branch_taken_i=1, target=0x0000_0046, FLUSH_CYCLES=1. Required: pc_new_o=0x44, pc_src_o=1, both flushes=1; next cycle state_o=3, misaligned_o=1, flush_if_id_o=1; then RUN.
3. Load-use: stall_i high 3 cycles in RUN. Required: fetch_en_o=0 and flush_id_ex_o=1 for 3 cycles; fetch_en_o=1 in the cycle stall_i drops.
4. Branch during stall: stall_i=1 and branch_taken_i=1, target 0x100. Required: pc_src_o=1, fetch_en_o=1, state_o=3.
5. Halt: halt_i pulse in RUN. Required: halted_o=1 and fetch_en_o=0 until resume_i. halt_i during stall is deferred until stall_i=0. halt_i and resume_i together in HALT -> RUN.
6. Perf: with FETCH_CTRL_PERF_EN and CNT_W=4, 20 redirects. Required: redirect_cnt_o=15. Without the macro, both counters=0.
